// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryption core: one round per clock, round key expanded on the fly.
// Valid/ready handshakes on both sides; outputs come straight from registers.

`timescale 1ns/1ps

// Forward S-box: multiplicative inverse in GF(2^8) (poly 0x11b) followed by the affine map.
module sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the inverse of a, and conveniently maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] t;
    logic [7:0] r;
    t = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      t = gf_mul(t, t);
      r = gf_mul(r, t);
    end
    return r;
  endfunction

  logic [7:0] w_inv;

  assign w_inv  = gf_inv(i_byte);
  assign o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
endmodule

module aes_encrypt_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext
);
  localparam int unsigned W_BLK  = 128;
  localparam int unsigned W_WORD = 32;
  localparam int unsigned W_BYTE = 8;
  localparam int unsigned N_BYTE = W_BLK / W_BYTE;
  localparam int unsigned N_COL  = 4;
  localparam int unsigned W_RND  = 4;
  localparam int unsigned N_RND  = 10;
  localparam logic [W_BYTE-1:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              w_in_ready_nxt;
  logic              w_out_valid_nxt;
  logic [W_BLK-1:0]  r_data;
  logic [W_BLK-1:0]  r_rk;
  logic [W_RND-1:0]  r_rnd;
  logic [W_BYTE-1:0] r_rcon;
  logic              w_rnd_ok;
  logic              w_last;
  logic [W_BLK-1:0]  w_rk_nxt;
  logic [W_BLK-1:0]  w_round;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  assign w_rnd_ok = (r_rnd != '0) && (r_rnd <= W_RND'(N_RND));
  assign w_last   = (r_rnd == W_RND'(N_RND));

  // Key schedule: RotWord/SubWord/Rcon on word 3, then the running XOR across words
  logic [W_WORD-1:0] w_rot;
  logic [W_WORD-1:0] w_sub;
  logic [W_WORD-1:0] w_temp;
  logic [W_BYTE-1:0] w_sub_b [N_COL];
  logic [W_WORD-1:0] w_kw    [N_COL];

  assign w_rot = {r_rk[W_WORD-W_BYTE-1:0], r_rk[W_WORD-1:W_WORD-W_BYTE]};

  for (genvar j = 0; j < N_COL; j++) begin : g_subword
    sbox u_sbox (
      .i_byte(w_rot[W_WORD-1-W_BYTE*j -: W_BYTE]),
      .o_byte(w_sub_b[j])
    );
  end

  assign w_sub   = {w_sub_b[0], w_sub_b[1], w_sub_b[2], w_sub_b[3]};
  assign w_temp  = w_sub ^ {r_rcon, 24'h00_0000};
  assign w_kw[0] = r_rk[127:96] ^ w_temp;
  assign w_kw[1] = r_rk[95:64]  ^ w_kw[0];
  assign w_kw[2] = r_rk[63:32]  ^ w_kw[1];
  assign w_kw[3] = r_rk[31:0]   ^ w_kw[2];
  assign w_rk_nxt = {w_kw[0], w_kw[1], w_kw[2], w_kw[3]};

  // State bytes are column-major: byte r + 4c sits at row r, column c
  logic [W_BYTE-1:0] w_sb [N_BYTE];
  logic [W_BYTE-1:0] w_sr [N_BYTE];
  logic [W_BYTE-1:0] w_mc [N_BYTE];

  for (genvar i = 0; i < N_BYTE; i++) begin : g_subbytes
    sbox u_sbox (
      .i_byte(r_data[W_BLK-1-W_BYTE*i -: W_BYTE]),
      .o_byte(w_sb[i])
    );
  end

  // ShiftRows rotates row r left by r columns; MixColumns per column
  for (genvar c = 0; c < N_COL; c++) begin : g_col
    for (genvar r = 0; r < N_COL; r++) begin : g_row
      assign w_sr[r+4*c] = w_sb[r + 4*((c+r)%4)];
    end
    assign w_mc[4*c]   = xtime(w_sr[4*c]) ^ xtime(w_sr[4*c+1]) ^ w_sr[4*c+1]
                       ^ w_sr[4*c+2] ^ w_sr[4*c+3];
    assign w_mc[4*c+1] = w_sr[4*c] ^ xtime(w_sr[4*c+1]) ^ xtime(w_sr[4*c+2])
                       ^ w_sr[4*c+2] ^ w_sr[4*c+3];
    assign w_mc[4*c+2] = w_sr[4*c] ^ w_sr[4*c+1] ^ xtime(w_sr[4*c+2])
                       ^ xtime(w_sr[4*c+3]) ^ w_sr[4*c+3];
    assign w_mc[4*c+3] = xtime(w_sr[4*c]) ^ w_sr[4*c] ^ w_sr[4*c+1]
                       ^ w_sr[4*c+2] ^ xtime(w_sr[4*c+3]);
  end

  for (genvar i = 0; i < N_BYTE; i++) begin : g_ark
    assign w_round[W_BLK-1-W_BYTE*i -: W_BYTE] =
      (w_last ? w_sr[i] : w_mc[i]) ^ w_rk_nxt[W_BLK-1-W_BYTE*i -: W_BYTE];
  end

  // Next-state and registered-output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_in_ready_nxt  = 1'b0;
    w_out_valid_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) w_state_nxt = S_ROUND;
      end
      S_ROUND: begin
        if (!w_rnd_ok)   w_state_nxt = S_IDLE;
        else if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_in_ready_nxt  = (w_state_nxt == S_IDLE);
    w_out_valid_nxt = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  // Datapath: load on acceptance, one round per ROUND cycle, hold in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_rk   <= '0;
      r_rnd  <= '0;
      r_rcon <= RCON_INIT;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_data <= plaintext ^ key;
            r_rk   <= key;
            r_rnd  <= W_RND'(1);
            r_rcon <= RCON_INIT;
          end
        end
        S_ROUND: begin
          if (w_rnd_ok) begin
            r_data <= w_round;
            r_rk   <= w_rk_nxt;
            r_rnd  <= w_last ? '0 : r_rnd + W_RND'(1);
            r_rcon <= xtime(r_rcon);
          end else begin
            r_rnd <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign ciphertext = r_data;
endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Self-checking bench for aes_encrypt_iter: known-answer vectors, back-pressure,
// mid-round reset and back-to-back random blocks against a byte-array AES model.

`timescale 1ns/1ps

module tb_aes_encrypt_iter;
  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_excl = 0;

  logic [7:0]   sb_tab [256];
  logic [127:0] exp_q [$];

  aes_encrypt_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .plaintext (plaintext),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ciphertext(ciphertext)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  always @(negedge clk) if (!rst && in_ready && out_valid) n_excl++;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box table from exp/log tables over generator 3, then the affine map
  task automatic build_sbox();
    logic [7:0] ex [256];
    int         lg [256];
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = x;
      lg[x] = i;
      x = x ^ xt(x);
    end
    for (int a = 0; a < 256; a++) begin
      b = (a == 0) ? 8'h00 : ex[(255 - lg[a]) % 255];
      sb_tab[a] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb_tab[tmp[31:24]], sb_tab[tmp[23:16]], sb_tab[tmp[15:8]], sb_tab[tmp[7:0]]}
            ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb_tab[s[i]];
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++)
          s[row+4*col] = t[row + 4*((col+row)%4)];
      if (r != 10) begin
        for (int col = 0; col < 4; col++) begin
          a0 = s[4*col]; a1 = s[4*col+1]; a2 = s[4*col+2]; a3 = s[4*col+3];
          s[4*col]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*col+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*col+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*col+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int col = 0; col < 4; col++)
        for (int j = 0; j < 4; j++)
          s[4*col+j] ^= w[4*r+col][31-8*j -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers (entered and left just after a negedge) ----------------
  task automatic send(input string tag, input logic [127:0] p, input logic [127:0] k);
    check_eq({tag, "_rdy"}, 128'(in_ready), 128'd1);
    plaintext = p;
    key       = k;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    plaintext = rand128();
    key       = rand128();
  endtask

  task automatic wait_result(input string tag, input logic [127:0] exp);
    int lat;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_lat"}, 128'(lat), 128'd10);
    check_eq({tag, "_ct"}, ciphertext, exp);
  endtask

  task automatic take_result(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_ovl_off"}, 128'(out_valid), 128'd0);
    check_eq({tag, "_rdy_back"}, 128'(in_ready), 128'd1);
  endtask

  // ---------------- main sequence ----------------
  logic [127:0] pa, ka, ea, pb, kb, eb, e;
  logic [127:0] vp [8];
  logic [127:0] vk [8];
  int cnt, idx, got, cyc, last_t, bad_gap;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; plaintext = '0; key = '0;
    build_sbox();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_rdy", 128'(in_ready), 128'd1);
    check_eq("rst_ovl", 128'(out_valid), 128'd0);
    check_eq("rst_ct", ciphertext, 128'h0);

    send("c1", PT_C1, K_C1);
    wait_result("c1", CT_C1);
    check_eq("c1_busy_rdy", 128'(in_ready), 128'd0);
    take_result("c1");

    out_ready = 1'b1;   // held high before the result exists
    send("appb", PT_B, K_B);
    wait_result("appb", CT_B);
    take_result("appb");

    send("zero", 128'h0, 128'h0);
    wait_result("zero", CT_Z);
    take_result("zero");

    // Back-pressure with a second block waiting
    pa = rand128(); ka = rand128(); ea = aes_ref(pa, ka);
    pb = rand128(); kb = rand128(); eb = aes_ref(pb, kb);
    send("bpA", pa, ka);
    wait_result("bpA", ea);
    plaintext = pb; key = kb; in_valid = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (ciphertext !== ea || in_ready !== 1'b0 || out_valid !== 1'b1) cnt++;
    end
    check_eq("bp_hold", 128'(cnt), 128'd0);
    check_eq("bp_ct_held", ciphertext, ea);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("bp_idle_rdy", 128'(in_ready), 128'd1);
    check_eq("bp_idle_ovl", 128'(out_valid), 128'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("bpB_taken", 128'(in_ready), 128'd0);
    wait_result("bpB", eb);
    take_result("bpB");

    // Reset during round 5, with in_valid asserted alongside reset
    send("mr", PT_C1, K_C1);
    repeat (4) @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; plaintext = PT_B; key = K_B;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check_eq("mr_rdy", 128'(in_ready), 128'd1);
    check_eq("mr_ovl", 128'(out_valid), 128'd0);
    check_eq("mr_ct", ciphertext, 128'h0);
    cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check_eq("mr_no_out", 128'(cnt), 128'd0);
    send("mr2", PT_C1, K_C1);
    wait_result("mr2", CT_C1);
    take_result("mr2");

    // Back-to-back random blocks; junk data on the inputs whenever the core is busy
    for (int i = 0; i < 8; i++) begin
      vp[i] = rand128();
      vk[i] = rand128();
    end
    idx = 0; got = 0; cyc = 0; last_t = 0; bad_gap = 0;
    out_ready = 1'b1;
    while (got < 8 && cyc < 300) begin
      if (out_valid) begin
        check_eq($sformatf("b2b%0d_avail", got), 128'(exp_q.size() > 0), 128'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'h0;
        check_eq($sformatf("b2b%0d_ct", got), ciphertext, e);
        if (got > 0 && cyc - last_t != 12) bad_gap++;
        last_t = cyc;
        got++;
      end
      if (in_ready && idx < 8) begin
        plaintext = vp[idx]; key = vk[idx]; in_valid = 1'b1;
        exp_q.push_back(aes_ref(vp[idx], vk[idx]));
        idx++;
      end else begin
        plaintext = rand128(); key = rand128(); in_valid = (idx < 8);
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0; in_valid = 1'b0;
    check_eq("b2b_count", 128'(got), 128'd8);
    check_eq("b2b_left", 128'(exp_q.size()), 128'd0);
    check_eq("b2b_period", 128'(bad_gap), 128'd0);

    check_eq("excl_rdy_vld", 128'(n_excl), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/aes_encrypt_iter.md
# aes_encrypt_iter

Iterative AES-128 encryption core: the forward counterpart of the decryption datapath, turning a 128-bit plaintext and 128-bit cipher key into ciphertext per FIPS-197. One round is executed per clock, with the round key expanded on the fly alongside the state. The core sits in the encryption path of the password store. It presents valid/ready handshakes on both sides so the block buffer and the storage writer can stall it.

## Interface
- No parameters; key length fixed at 128 bits, Nr = 10.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  plaintext/key present.
- in_ready  out  1  core can accept a block; high only in IDLE.
- plaintext  in  128  block; byte 0 = bits [127:120], column-major state per FIPS-197.
- key  in  128  cipher key, same byte order.
- out_valid  out  1  ciphertext valid; held until accepted.
- out_ready  in  1  downstream accepts ciphertext.
- ciphertext  out  128  result, same byte order.

## Operation
- States: IDLE, ROUND, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at an edge: state_reg <= plaintext ^ key, rk_reg <= key, rnd <= 1, rcon <= 8'h01, go to ROUND.
- ROUND, each edge:
  - Next round key: rk' = KeyExpand(rk_reg, rcon) using RotWord, SubWord and Rcon on word 3; rk_reg <= rk'.
  - state_reg <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state_reg))), rk').
  - MixColumns is bypassed when rnd == 10.
  - rnd increments; rcon <= xtime(rcon), giving the sequence 01,02,04,08,10,20,40,80,1b,36.
  - After the rnd == 10 edge, go to DONE.
- DONE:
  - out_valid = 1; ciphertext = state_reg, stable.
  - On out_valid & out_ready at an edge: go to IDLE.
  - No new block is accepted in the same cycle.
- Datapath resources:
  - 16 forward S-box instances (module sbox, 8-bit in/out, combinational) for SubBytes.
  - 4 additional instances for SubWord.
  - xtime over GF(2^8) with polynomial 0x11b.
- Inputs are sampled only at the acceptance edge. Changes on plaintext/key while busy are ignored.
- rnd is 4 bits. Values 0 and 11–15 are unreachable; if reached, the FSM falls back to IDLE.

## Timing
- Reset (rst high at an edge):
  - state <= IDLE; in_ready = 1 from the following cycle.
  - out_valid = 0, ciphertext = 128'h0, rnd = 0, rcon = 8'h01.
- Reset mid-operation (ROUND or DONE) aborts the block. No out_valid is produced for it.
- in_valid is ignored during a cycle in which rst is high.
- Latency: acceptance at edge E0 leads to out_valid high after edge E10, i.e. 10 cycles after acceptance.
- Minimum block period is 12 cycles: 1 accept + 10 rounds + 1 output handshake. in_ready returns the cycle after output acceptance.
- out_ready held low: DONE persists indefinitely with ciphertext unchanged and in_ready = 0.
- out_ready high before out_valid has no effect.
- in_ready and out_valid are never high simultaneously.
- Outputs are decoded from registered state. No combinational path runs from in_valid/out_ready to any output.

## Test plan
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after acceptance.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
- All-zero key and pt -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Back-pressure:
  - Stimulus: out_ready low for 20 cycles after out_valid rises, with in_valid held high and new data applied.
  - Required: ciphertext stable, in_ready 0, second block not accepted.
  - Then raise out_ready: IDLE next cycle, second block accepted on the following edge, and its result correct.
- Reset mid-round: rst pulsed at round 5 -> out_valid stays 0, in_ready 1 the next cycle, ciphertext 0. A fresh App. C.1 vector then completes correctly.
- Back-to-back: out_ready and in_valid held high with 8 random vectors checked against a software AES model -> one result every 12 cycles, no drops or duplicates.
